// File: rtl/parking_manager_sched.sv
// Two-class parking occupancy manager with an hour-driven university capacity schedule.
// Grants or denies entries, tracks exits, and optionally spills university cars into general space.
module parking_manager_sched #(
    parameter int unsigned TOTAL_SPACES    = 700,
    parameter int unsigned UNI_CAP_MAX     = 500,
    parameter int unsigned UNI_CAP_MIN     = 200,
    parameter int unsigned UNI_STEP        = 50,
    parameter int unsigned START_HOUR      = 8,
    parameter int unsigned RAMP_START_HOUR = 13,
    parameter int unsigned TICKS_PER_HOUR  = 3600,
    parameter int unsigned UNI_SPILL       = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             car_entered,
    input  logic             is_uni_car_entered,
    input  logic             car_exited,
    input  logic             is_uni_car_exited,
    output logic [CNT_W-1:0] uni_car_parked,
    output logic [CNT_W-1:0] parked_car,
    output logic [CNT_W-1:0] uni_spilled,
    output logic [CNT_W-1:0] uni_capacity,
    output logic [CNT_W-1:0] uni_vacated_space,
    output logic [CNT_W-1:0] vacated_space,
    output logic             uni_is_vacated_space,
    output logic             is_vacated_space,
    output logic [4:0]       hour,
    output logic             entry_granted,
    output logic             entry_denied,
    output logic             exit_error
);

    localparam int unsigned TICK_W = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_HOUR - 1);
    localparam logic [CNT_W-1:0]  TOTAL     = CNT_W'(TOTAL_SPACES);
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

    logic [TICK_W-1:0] tick_q;
    logic [4:0]        hour_q;
    logic [CNT_W-1:0]  uni_q, uni_d;
    logic [CNT_W-1:0]  gen_q, gen_d;
    logic [CNT_W-1:0]  spill_q, spill_d;
    logic              granted_q, granted_d;
    logic              denied_q, denied_d;
    logic              err_q, err_d;

    logic [CNT_W-1:0]  sched_cap, cap, gen_cap;
    logic [CNT_W-1:0]  cap_x, gen_cap_x;

    function automatic logic [CNT_W-1:0] sched(input logic [4:0] h);
        int unsigned hh;
        int unsigned dec;
        hh = 32'(h);
        if (hh < RAMP_START_HOUR) return CNT_W'(UNI_CAP_MAX);
        dec = UNI_STEP * (hh - RAMP_START_HOUR + 1);
        if (dec + UNI_CAP_MIN >= UNI_CAP_MAX) return CNT_W'(UNI_CAP_MIN);
        return CNT_W'(UNI_CAP_MAX - dec);
    endfunction

    // Capacity never drops below the cars already parked, so a shrink never evicts.
    assign sched_cap = sched(hour_q);
    assign cap       = (uni_q > sched_cap) ? uni_q : sched_cap;
    assign gen_cap   = (cap >= TOTAL) ? '0 : TOTAL - cap;

    always_comb begin
        uni_d     = uni_q;
        gen_d     = gen_q;
        spill_d   = spill_q;
        granted_d = 1'b0;
        denied_d  = 1'b0;
        err_d     = 1'b0;
        cap_x     = cap;
        gen_cap_x = gen_cap;
        if (start) begin
            if (car_exited) begin
                if (is_uni_car_exited) begin
                    if (spill_q != '0) begin
                        spill_d = spill_q - ONE;
                        gen_d   = gen_q - ONE;
                    end else if (uni_q != '0) begin
                        uni_d = uni_q - ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (gen_q != spill_q) begin
                    gen_d = gen_q - ONE;
                end else begin
                    err_d = 1'b1;
                end
            end
            // Entry sees capacity recomputed from post-exit counts.
            cap_x     = (uni_d > sched_cap) ? uni_d : sched_cap;
            gen_cap_x = (cap_x >= TOTAL) ? '0 : TOTAL - cap_x;
            if (car_entered) begin
                if (is_uni_car_entered && (uni_d < sched_cap)) begin
                    uni_d     = uni_d + ONE;
                    granted_d = 1'b1;
                end else if (is_uni_car_entered && (UNI_SPILL != 0) && (gen_d < gen_cap_x)) begin
                    gen_d     = gen_d + ONE;
                    spill_d   = spill_d + ONE;
                    granted_d = 1'b1;
                end else if (!is_uni_car_entered && (gen_d < gen_cap_x)) begin
                    gen_d     = gen_d + ONE;
                    granted_d = 1'b1;
                end else begin
                    denied_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= '0;
            hour_q    <= 5'(START_HOUR);
            uni_q     <= '0;
            gen_q     <= '0;
            spill_q   <= '0;
            granted_q <= 1'b0;
            denied_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (start) begin
                if (tick_q == TICK_LAST) begin
                    tick_q <= '0;
                    hour_q <= (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    tick_q <= tick_q + TICK_W'(1);
                end
            end
            uni_q     <= uni_d;
            gen_q     <= gen_d;
            spill_q   <= spill_d;
            granted_q <= granted_d;
            denied_q  <= denied_d;
            err_q     <= err_d;
        end
    end

    assign uni_car_parked       = uni_q;
    assign parked_car           = gen_q;
    assign uni_spilled          = spill_q;
    assign uni_capacity         = cap;
    assign uni_vacated_space    = cap - uni_q;
    assign vacated_space        = (gen_q >= gen_cap) ? '0 : gen_cap - gen_q;
    assign uni_is_vacated_space = (uni_vacated_space != '0);
    assign is_vacated_space     = (vacated_space != '0);
    assign hour                 = hour_q;
    assign entry_granted        = granted_q;
    assign entry_denied         = denied_q;
    assign exit_error           = err_q;

endmodule

// File: tb/tb_parking_manager_sched.sv
// Directed bench for parking_manager_sched with a small schedule (8 spaces, 5->2 uni cap, 10 ticks/hour).
module tb_parking_manager_sched;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset, start;
    logic             car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic [CNT_W-1:0] uni_car_parked, parked_car, uni_spilled, uni_capacity;
    logic [CNT_W-1:0] uni_vacated_space, vacated_space;
    logic             uni_is_vacated_space, is_vacated_space;
    logic [4:0]       hour;
    logic             entry_granted, entry_denied, exit_error;

    int n_tests = 0;
    int n_fail  = 0;

    parking_manager_sched #(
        .TOTAL_SPACES(8), .UNI_CAP_MAX(5), .UNI_CAP_MIN(2), .UNI_STEP(1),
        .START_HOUR(8), .RAMP_START_HOUR(9), .TICKS_PER_HOUR(10), .UNI_SPILL(1),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
        .uni_car_parked(uni_car_parked), .parked_car(parked_car), .uni_spilled(uni_spilled),
        .uni_capacity(uni_capacity), .uni_vacated_space(uni_vacated_space),
        .vacated_space(vacated_space), .uni_is_vacated_space(uni_is_vacated_space),
        .is_vacated_space(is_vacated_space), .hour(hour),
        .entry_granted(entry_granted), .entry_denied(entry_denied), .exit_error(exit_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ev(input logic en, input logic uen, input logic ex, input logic uex);
        car_entered        = en;
        is_uni_car_entered = uen;
        car_exited         = ex;
        is_uni_car_exited  = uex;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        set_ev(0, 0, 0, 0);
        step();
        reset = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int unsigned u, input int unsigned g,
                                input int unsigned s);
        check_eq({tag, ".uni"}, uni_car_parked, u);
        check_eq({tag, ".gen"}, parked_car, g);
        check_eq({tag, ".spill"}, uni_spilled, s);
    endtask

    initial begin
        do_reset();

        // Reset state
        check_counts("rst", 0, 0, 0);
        check_eq("rst.hour", hour, 8);
        check_eq("rst.cap", uni_capacity, 5);
        check_eq("rst.uvac", uni_vacated_space, 5);
        check_eq("rst.vac", vacated_space, 3);
        check_eq("rst.flags", {uni_is_vacated_space, is_vacated_space}, 2'b11);
        check_eq("rst.pulses", {entry_granted, entry_denied, exit_error}, 3'b000);

        // Time ramp and hour wrap
        start = 1'b1;
        repeat (10) step();
        check_eq("t1.hour", hour, 9);
        check_eq("t1.cap", uni_capacity, 4);
        check_eq("t1.vac", vacated_space, 4);
        check_eq("t1.uvac", uni_vacated_space, 4);
        repeat (30) step();
        check_eq("t1.hour12", hour, 12);
        check_eq("t1.cap12", uni_capacity, 2);
        repeat (10) step();
        check_eq("t1.cap13", uni_capacity, 2);
        repeat (100) step();
        check_eq("t1.hour23", hour, 23);
        repeat (10) step();
        check_eq("t1.wrap", hour, 0);
        check_eq("t1.capwrap", uni_capacity, 5);

        // University fill, then spill
        do_reset();
        start = 1'b1;
        set_ev(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t2.grant", entry_granted, 1);
        end
        check_counts("t2.full", 5, 0, 0);
        check_eq("t2.uflag", uni_is_vacated_space, 0);
        step();
        check_eq("t2.spillgrant", entry_granted, 1);
        check_counts("t2.spill", 5, 1, 1);
        check_eq("t2.vac", vacated_space, 2);

        // General exit with only spilled cars, then university exit
        set_ev(0, 0, 1, 0);
        step();
        check_eq("t3.err", exit_error, 1);
        check_counts("t3.err", 5, 1, 1);
        set_ev(0, 0, 1, 1);
        step();
        check_eq("t3.noerr", exit_error, 0);
        check_counts("t3.uexit", 5, 0, 0);
        set_ev(0, 0, 0, 0);

        // University exit on an empty lot
        do_reset();
        start = 1'b1;
        set_ev(0, 0, 1, 1);
        step();
        check_eq("t3b.err", exit_error, 1);
        check_counts("t3b", 0, 0, 0);

        // General zone full; lone entry denied; exit+entry same cycle granted
        set_ev(1, 0, 0, 0);
        repeat (3) step();
        check_eq("t4.gen3", parked_car, 3);
        check_eq("t4.vac0", vacated_space, 0);
        check_eq("t4.flag", is_vacated_space, 0);
        step();
        check_eq("t4.deny", entry_denied, 1);
        check_eq("t4.denygen", parked_car, 3);
        set_ev(1, 0, 1, 0);
        step();
        check_eq("t4.swapgrant", entry_granted, 1);
        check_eq("t4.swapgen", parked_car, 3);
        set_ev(0, 0, 0, 0);

        // Capacity clamp at hour 10 with 5 university cars, release on exits
        do_reset();
        start = 1'b1;
        set_ev(1, 1, 0, 0);
        repeat (5) step();
        set_ev(0, 0, 0, 0);
        repeat (15) step();
        check_eq("t5.hour", hour, 10);
        check_eq("t5.cap", uni_capacity, 5);
        check_eq("t5.uvac", uni_vacated_space, 0);
        check_eq("t5.vac", vacated_space, 3);
        set_ev(0, 0, 1, 1);
        repeat (2) step();
        set_ev(0, 0, 0, 0);
        check_eq("t5.uni", uni_car_parked, 3);
        check_eq("t5.cap3", uni_capacity, 3);

        // Mid-run reset beats events; start=0 freezes time and ignores events
        reset = 1'b1;
        start = 1'b1;
        set_ev(1, 1, 0, 0);
        step();
        check_counts("t6.rst", 0, 0, 0);
        check_eq("t6.hour", hour, 8);
        check_eq("t6.grant", entry_granted, 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (15) step();
        check_counts("t6.idle", 0, 0, 0);
        check_eq("t6.frozen", hour, 8);
        check_eq("t6.nopulse", {entry_granted, entry_denied, exit_error}, 3'b000);
        set_ev(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
